// File: rtl/w0_fifo_128.sv
// Dual-clock FWFT FIFO, 512 x 128, for the frame-buffer pixel<->AXI paths.
// Gray-coded pointers cross through 2-flop synchronizers; flags are registered and pessimistic.
module w0_fifo_128 #(
    parameter int DATA_WIDTH        = 128,
    parameter int ADDR_WIDTH        = 9,
    parameter int PROG_FULL_THRESH  = 256,
    parameter int PROG_EMPTY_THRESH = 128
) (
    input  logic                  a_rst_i,
    input  logic                  wr_clk_i,
    input  logic                  rd_clk_i,
    input  logic                  wr_en_i,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  full_o,
    output logic                  prog_full_o,
    input  logic                  rd_en_i,
    output logic [DATA_WIDTH-1:0] rdata,
    output logic                  empty_o,
    output logic                  prog_empty_o
);

    localparam int              PW     = ADDR_WIDTH + 1;
    localparam logic [PW-1:0]   DEPTH  = PW'(2 ** ADDR_WIDTH);
    localparam logic [PW-1:0]   PF_LVL = PW'(PROG_FULL_THRESH);
    localparam logic [PW-1:0]   PE_LVL = PW'(PROG_EMPTY_THRESH);
    localparam logic [PW-1:0]   ONE    = PW'(1);

    function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
        logic [PW-1:0] b;
        b[PW-1] = g[PW-1];
        for (int i = PW - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    logic [DATA_WIDTH-1:0] mem [0:(2**ADDR_WIDTH)-1];

    // Write domain
    logic [1:0]    wrst_q, wrst_d;
    logic          w_in_rst;
    logic [PW-1:0] wptr_q, wptr_d, wgray_q, wgray_d;
    logic [PW-1:0] rq1_q, rq1_d, rq2_q, rq2_d;
    logic          full_q, full_d, prog_full_q, prog_full_d;
    logic [PW-1:0] rsync, wcnt;
    logic          wr_fire;

    // Read domain
    logic [1:0]            rrst_q, rrst_d;
    logic                  r_in_rst;
    logic [PW-1:0]         rptr_q, rptr_d, rgray_q, rgray_d;
    logic [PW-1:0]         wq1_q, wq1_d, wq2_q, wq2_d;
    logic                  valid_q, valid_d, prog_empty_q, prog_empty_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic [PW-1:0]         wsync, faddr, rcnt;
    logic                  avail, pop, fetch;

    assign w_in_rst = wrst_q[1];
    assign r_in_rst = rrst_q[1];

    always_comb begin
        wrst_d      = {wrst_q[0], 1'b0};
        rq1_d       = rgray_q;
        rq2_d       = rq1_q;
        rsync       = gray2bin(rq2_q);
        wr_fire     = wr_en_i && !full_q && !w_in_rst;
        wptr_d      = wptr_q + (wr_fire ? ONE : '0);
        // Synced read pointer lags, so this count can only over-read.
        wcnt        = wptr_d - rsync;
        full_d      = (wcnt == DEPTH);
        prog_full_d = (wcnt >= PF_LVL);
        if (w_in_rst) begin
            wptr_d      = '0;
            full_d      = 1'b0;
            prog_full_d = 1'b0;
        end
        wgray_d = bin2gray(wptr_d);
    end

    always_ff @(posedge wr_clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            wrst_q      <= 2'b11;
            wptr_q      <= '0;
            wgray_q     <= '0;
            rq1_q       <= '0;
            rq2_q       <= '0;
            full_q      <= 1'b0;
            prog_full_q <= 1'b0;
        end else begin
            wrst_q      <= wrst_d;
            wptr_q      <= wptr_d;
            wgray_q     <= wgray_d;
            rq1_q       <= rq1_d;
            rq2_q       <= rq2_d;
            full_q      <= full_d;
            prog_full_q <= prog_full_d;
        end
    end

    always_ff @(posedge wr_clk_i) begin
        if (wr_fire) begin
            mem[wptr_q[ADDR_WIDTH-1:0]] <= wdata;
        end
    end

    // rptr counts popped words; the output-stage word still occupies its RAM slot,
    // so the write side keeps counting it and never overwrites it.
    always_comb begin
        rrst_d       = {rrst_q[0], 1'b0};
        wq1_d        = wgray_q;
        wq2_d        = wq1_q;
        wsync        = gray2bin(wq2_q);
        faddr        = rptr_q + (valid_q ? ONE : '0);
        avail        = (wsync != faddr);
        pop          = rd_en_i && valid_q && !r_in_rst;
        fetch        = avail && (!valid_q || pop) && !r_in_rst;
        rptr_d       = rptr_q + (pop ? ONE : '0);
        valid_d      = fetch || (valid_q && !pop);
        rdata_d      = fetch ? mem[faddr[ADDR_WIDTH-1:0]] : rdata_q;
        rcnt         = wsync - rptr_d;
        prog_empty_d = (rcnt < PE_LVL);
        if (r_in_rst) begin
            rptr_d       = '0;
            valid_d      = 1'b0;
            rdata_d      = '0;
            prog_empty_d = 1'b1;
        end
        rgray_d = bin2gray(rptr_d);
    end

    always_ff @(posedge rd_clk_i or posedge a_rst_i) begin
        if (a_rst_i) begin
            rrst_q       <= 2'b11;
            rptr_q       <= '0;
            rgray_q      <= '0;
            wq1_q        <= '0;
            wq2_q        <= '0;
            valid_q      <= 1'b0;
            rdata_q      <= '0;
            prog_empty_q <= 1'b1;
        end else begin
            rrst_q       <= rrst_d;
            rptr_q       <= rptr_d;
            rgray_q      <= rgray_d;
            wq1_q        <= wq1_d;
            wq2_q        <= wq2_d;
            valid_q      <= valid_d;
            rdata_q      <= rdata_d;
            prog_empty_q <= prog_empty_d;
        end
    end

    assign full_o       = full_q;
    assign prog_full_o  = prog_full_q;
    assign rdata        = rdata_q;
    assign empty_o      = !valid_q;
    assign prog_empty_o = prog_empty_q;

endmodule

// File: tb/tb_w0_fifo_128.sv
// Bench for w0_fifo_128: queue model of FIFO contents, per-cycle compare of head word and
// flag implications, plus directed checks with literal expectations.
module tb_w0_fifo_128;
  localparam int DW = 128;

  logic          a_rst_i  = 1'b0;
  logic          wr_clk_i = 1'b0;
  logic          rd_clk_i = 1'b0;
  logic          wr_en_i  = 1'b0;
  logic          rd_en_i  = 1'b0;
  logic [DW-1:0] wdata    = '0;
  logic          full_o, prog_full_o, empty_o, prog_empty_o;
  logic [DW-1:0] rdata;

  int wr_half = 50;
  int rd_half = 67;

  int total = 0;
  int bad = 0;
  bit chk_en = 0;
  int wr_count = 0;
  int rd_count = 0;
  logic [DW-1:0] exp_q[$];

  w0_fifo_128 dut (
    .a_rst_i      (a_rst_i),
    .wr_clk_i     (wr_clk_i),
    .rd_clk_i     (rd_clk_i),
    .wr_en_i      (wr_en_i),
    .wdata        (wdata),
    .full_o       (full_o),
    .prog_full_o  (prog_full_o),
    .rd_en_i      (rd_en_i),
    .rdata        (rdata),
    .empty_o      (empty_o),
    .prog_empty_o (prog_empty_o)
  );

  // clock / reset
  always #(wr_half) wr_clk_i = ~wr_clk_i;
  always #(rd_half) rd_clk_i = ~rd_clk_i;

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%0h expected=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic do_reset();
    @(negedge wr_clk_i);
    a_rst_i = 1'b1;
    exp_q.delete();
    @(negedge wr_clk_i);
    a_rst_i = 1'b0;
  endtask

  // driver tasks
  task automatic wr_push(input logic [DW-1:0] d);
    @(negedge wr_clk_i);
    wr_en_i = 1'b1;
    wdata   = d;
    @(negedge wr_clk_i);
    wr_en_i = 1'b0;
  endtask

  task automatic rd_pop();
    @(negedge rd_clk_i);
    rd_en_i = 1'b1;
    @(negedge rd_clk_i);
    rd_en_i = 1'b0;
  endtask

  task automatic wr_cycles(input int n);
    repeat (n) @(negedge wr_clk_i);
  endtask

  task automatic rd_cycles(input int n);
    repeat (n) @(negedge rd_clk_i);
  endtask

  // Deadline measured from the write edge that just happened inside wr_push.
  function automatic longint cross_deadline();
    return longint'($time) - wr_half + 4 * wr_half + 8 * rd_half;
  endfunction

  // sel 0: wait for empty_o low; sel 1: wait for prog_empty_o low
  task automatic wait_flag(input int sel, input longint deadline, input string name);
    bit ok;
    ok = 1'b0;
    forever begin
      if ((sel == 0 && !empty_o) || (sel == 1 && !prog_empty_o)) begin
        ok = 1'b1;
        break;
      end
      if (longint'($time) > deadline) break;
      @(negedge rd_clk_i);
    end
    check(name, ok, 1'b1);
  endtask

  task automatic stream(input int n, input int wh, input int rh, input logic [DW-1:0] base);
    int wcyc;
    int rcyc;
    wr_half  = wh;
    rd_half  = rh;
    wr_count = 0;
    rd_count = 0;
    wcyc     = 0;
    rcyc     = 0;
    fork
      begin
        forever begin
          @(negedge wr_clk_i);
          if (wr_count >= n || wcyc >= 30000) break;
          wr_en_i = ($urandom_range(0, 3) != 0);
          wdata   = base + DW'(wr_count);
          wcyc++;
        end
        wr_en_i = 1'b0;
      end
      begin
        forever begin
          @(negedge rd_clk_i);
          if (rd_count >= n || rcyc >= 30000) break;
          rd_en_i = ($urandom_range(0, 3) != 0);
          rcyc++;
        end
        rd_en_i = 1'b0;
      end
    join
    check("stream_wr_count", wr_count, n);
    check("stream_rd_count", rd_count, n);
    rd_cycles(6);
    check("stream_empty_after", empty_o, 1'b1);
    check("stream_model_drained", exp_q.size(), 0);
  endtask

  // scoreboard: model updates on accepted operations
  always @(posedge wr_clk_i) begin
    if (wr_en_i && !full_o) begin
      exp_q.push_back(wdata);
      wr_count++;
    end
  end

  always @(posedge rd_clk_i) begin
    if (chk_en && rd_en_i && !empty_o) begin
      check("pop_nonempty", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) begin
        check("pop_data", rdata, exp_q[0]);
        void'(exp_q.pop_front());
      end
      rd_count++;
    end
  end

  // per-cycle compare against the model
  always @(negedge rd_clk_i) begin
    if (chk_en) begin
      if (!empty_o) begin
        check("head_present", exp_q.size() != 0, 1'b1);
        if (exp_q.size() != 0) check("head_data", rdata, exp_q[0]);
      end
      if (!prog_empty_o) check("prog_empty_early", exp_q.size() >= 128, 1'b1);
    end
  end

  always @(negedge wr_clk_i) begin
    if (chk_en) begin
      if (!full_o) check("full_early", exp_q.size() < 512, 1'b1);
      if (!prog_full_o) check("prog_full_early", exp_q.size() < 256, 1'b1);
    end
  end

  initial begin
    logic [DW-1:0] a5_word;
    longint dl;
    a5_word = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_32A5;

    // reset: one-cycle pulse
    wr_cycles(2);
    do_reset();
    check("rst_empty", empty_o, 1'b1);
    check("rst_prog_empty", prog_empty_o, 1'b1);
    check("rst_full", full_o, 1'b0);
    check("rst_prog_full", prog_full_o, 1'b0);
    check("rst_rdata", rdata, '0);
    chk_en = 1'b1;
    wr_cycles(4);
    rd_cycles(4);

    // FWFT: single word appears without rd_en_i
    wr_push(a5_word);
    dl = cross_deadline();
    wait_flag(0, dl, "fwft_latency");
    check("fwft_rdata", rdata, a5_word);
    rd_pop();
    check("fwft_empty_after_pop", empty_o, 1'b1);

    // burst threshold
    for (int i = 0; i < 127; i++) wr_push(DW'(1000 + i));
    rd_cycles(10);
    check("burst_127_prog_empty", prog_empty_o, 1'b1);
    check("burst_127_not_empty", empty_o, 1'b0);
    wr_push(DW'(1127));
    dl = cross_deadline();
    wait_flag(1, dl, "burst_128_prog_empty_low");
    rd_pop();
    check("burst_pop_prog_empty", prog_empty_o, 1'b1);
    for (int i = 0; i < 127; i++) rd_pop();
    check("burst_drained_empty", empty_o, 1'b1);
    wr_cycles(8);

    // fill to full, drop the 513th, read back 0..511
    for (int i = 0; i < 512; i++) begin
      wr_push(DW'(i));
      if (i == 254) check("fill_255_prog_full", prog_full_o, 1'b0);
      if (i == 255) check("fill_256_prog_full", prog_full_o, 1'b1);
      if (i == 510) check("fill_511_full", full_o, 1'b0);
      if (i == 511) check("fill_512_full", full_o, 1'b1);
    end
    wr_push(DW'(512));
    check("fill_513_still_full", full_o, 1'b1);
    rd_cycles(8);
    check("fill_prog_empty_low", prog_empty_o, 1'b0);
    for (int i = 0; i < 512; i++) begin
      check("fill_seq", rdata, DW'(i));
      rd_pop();
    end
    check("fill_empty_after_512", empty_o, 1'b1);
    rd_cycles(8);
    check("fill_513_dropped", empty_o, 1'b1);
    wr_cycles(8);
    check("fill_full_released", full_o, 1'b0);
    check("fill_prog_full_released", prog_full_o, 1'b0);

    // wrap and streaming at 1:3 and 3:1
    stream(2500, 50, 150, 128'h1_0000);
    stream(2500, 150, 50, 128'h2_0000);
    wr_half = 50;
    rd_half = 67;
    wr_cycles(8);

    // mid-operation reset
    for (int i = 0; i < 300; i++) wr_push(DW'(32'h3_0000 + i));
    rd_cycles(8);
    check("mid_prog_full_before", prog_full_o, 1'b1);
    do_reset();
    check("mid_rst_empty", empty_o, 1'b1);
    check("mid_rst_prog_full", prog_full_o, 1'b0);
    check("mid_rst_full", full_o, 1'b0);
    check("mid_rst_rdata", rdata, '0);
    wr_cycles(4);
    rd_cycles(4);
    wr_push(128'hBEEF);
    dl = cross_deadline();
    wait_flag(0, dl, "mid_first_word_latency");
    check("mid_first_word", rdata, 128'hBEEF);
    rd_pop();
    check("mid_empty_after_pop", empty_o, 1'b1);

    rd_cycles(4);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(20_000_000);
    bad++;
    $display("FAIL watchdog: simulation time limit reached, wr_count=%0d rd_count=%0d", wr_count, rd_count);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
